// File: rtl/bitbrick_accumulator.sv
// bitbrick_accumulator
//   Sums NUM_BB signed bitbrick products per beat in a registered reduction
//   stage, accumulates beat sums over a group terminated by in_last, and emits
//   one saturated ACC_W-bit signed result per group on a valid/ready port.
//   Two pipeline stages: stage 1 holds the reduced beat, stage 2 holds the
//   running group sum and the pending result. A pending result that is not
//   taken downstream stalls both stages.
module bitbrick_accumulator #(
  parameter int NUM_BB = 16,
  parameter int PROD_W = 10,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_BB*PROD_W-1:0] in_prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_acc,
  output logic                     out_ovf
);

  // Full-precision width of one beat sum: never overflows.
  localparam int SUM_W = PROD_W + $clog2(NUM_BB);
  // Working width of the accumulate adder. One bit wider than the larger
  // operand, so it stays exact even if ACC_W is configured below SUM_W.
  localparam int WIDE  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  // Saturation bounds expressed at the working width.
  localparam logic [WIDE-1:0] SAT_MAX = {{(WIDE-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic [WIDE-1:0] SAT_MIN = {{(WIDE-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------------------
  // Stage 1: reduction of the incoming beat
  // ---------------------------------------------------------------------------
  // Each product is sign-extended to the beat-sum width. Products are forced
  // to zero on bubbles so unknown data never reaches the registers.
  logic [SUM_W-1:0] prod_ext [NUM_BB];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BB; gi++) begin : g_prod_ext
      assign prod_ext[gi] = in_valid ? SUM_W'($signed(in_prod[gi*PROD_W +: PROD_W]))
                                     : '0;
    end
  endgenerate

  logic [SUM_W-1:0] beat_sum;

  // Combinational sum of all extended products (two's complement, exact).
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NUM_BB; i++) begin
      beat_sum = beat_sum + prod_ext[i];
    end
  end

  logic             s1_valid;
  logic             s1_last;
  logic [SUM_W-1:0] s1_sum;

  // Stage-1 register: captures a beat (or bubble) whenever the pipe moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last  <= in_last & in_valid;
      s1_sum   <= beat_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate with saturation
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc;
  logic             ovf_acc;
  logic [WIDE-1:0]  acc_ext;
  logic [WIDE-1:0]  s1_ext;
  logic [WIDE-1:0]  sum_wide;
  logic [ACC_W-1:0] sat_sum;
  logic             sat;

  assign acc_ext  = {{(WIDE-ACC_W){acc[ACC_W-1]}}, acc};
  assign s1_ext   = {{(WIDE-SUM_W){s1_sum[SUM_W-1]}}, s1_sum};
  assign sum_wide = acc_ext + s1_ext;

  // Clip the exact sum into the signed ACC_W range and flag any clipping.
  always_comb begin
    sat_sum = sum_wide[ACC_W-1:0];
    sat     = 1'b0;
    if ($signed(sum_wide) > $signed(SAT_MAX)) begin
      sat_sum = SAT_MAX[ACC_W-1:0];
      sat     = 1'b1;
    end else if ($signed(sum_wide) < $signed(SAT_MIN)) begin
      sat_sum = SAT_MIN[ACC_W-1:0];
      sat     = 1'b1;
    end
  end

  // Stage-2 register: running group sum, sticky overflow and the output slot.
  // A result leaving and a new result loading in the same cycle keeps
  // out_valid high with the new data (the later assignment wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (s1_valid && !stall) begin
        if (s1_last) begin
          out_acc   <= sat_sum;
          out_ovf   <= ovf_acc | sat;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf_acc   <= 1'b0;
        end else begin
          acc       <= sat_sum;
          ovf_acc   <= ovf_acc | sat;
        end
      end
    end
  end

endmodule
